// File: rtl/cam_pkg.sv
// Shared camera-bus definitions: FSM encoding, default geometry, data_out lanes.
// Used by camera_capture and cam_bus_sync.
package cam_pkg;

  localparam int FRAME_W_DEF = 640;
  localparam int FRAME_H_DEF = 480;

  localparam int BYTE_W = 8;
  localparam int X_W    = 10;
  localparam int Y_W    = 9;

  localparam int LUMA_MSB   = 23;
  localparam int LUMA_LSB   = 16;
  localparam int CHROMA_MSB = 15;
  localparam int CHROMA_LSB = 8;

  localparam logic [1:0] ST_WAIT_BLANK = 2'd0;
  localparam logic [1:0] ST_WAIT_START = 2'd1;
  localparam logic [1:0] ST_ACTIVE     = 2'd2;
  localparam logic [1:0] ST_DONE       = 2'd3;

  typedef enum logic [1:0] {
    WAIT_BLANK = ST_WAIT_BLANK,
    WAIT_START = ST_WAIT_START,
    ACTIVE     = ST_ACTIVE,
    DONE       = ST_DONE
  } cap_state_e;

  function automatic logic [31:0] pack_pixel(
    input logic [BYTE_W-1:0] b0,
    input logic [BYTE_W-1:0] b1
  );
    logic [31:0] w;
    w = '0;
    w[LUMA_MSB:LUMA_LSB]     = b0;
    w[CHROMA_MSB:CHROMA_LSB] = b1;
    return w;
  endfunction

endpackage

// File: rtl/camera_capture_if.sv
// Camera parallel bus plus pixel output bundle.
// master drives the camera bus, slave is the capture block.
interface camera_capture_if;
  import cam_pkg::*;

  logic              cam_vsync;
  logic              cam_href;
  logic [BYTE_W-1:0] cam_data;
  logic [31:0]       data_out;
  logic              pixel_done;
  logic              frame_done;
  logic              frame_err;
  logic [X_W-1:0]    pix_x;
  logic [Y_W-1:0]    pix_y;

  modport master (
    output cam_vsync, cam_href, cam_data,
    input  data_out, pixel_done, frame_done,
    input  frame_err, pix_x, pix_y
  );

  modport slave (
    input  cam_vsync, cam_href, cam_data,
    output data_out, pixel_done, frame_done,
    output frame_err, pix_x, pix_y
  );

endinterface

// File: rtl/cam_bus_sync.sv
// Camera bus input register stage with vsync/href edge detection.
// Reusable by any consumer of the OV7670 parallel bus.
module cam_bus_sync
  import cam_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              vsync_i,
  input  logic              href_i,
  input  logic [BYTE_W-1:0] data_i,
  output logic              vsync_r,
  output logic              href_r,
  output logic [BYTE_W-1:0] data_r,
  output logic              vsync_rise,
  output logic              vsync_fall,
  output logic              href_fall
);

  logic              vsync_q, vsync_d;
  logic              href_q, href_d;
  logic [BYTE_W-1:0] data_q, data_d;
  logic              vsync_p_q, vsync_p_d;
  logic              href_p_q, href_p_d;

  always_comb begin
    vsync_d   = vsync_i;
    href_d    = href_i;
    data_d    = data_i;
    vsync_p_d = vsync_q;
    href_p_d  = href_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      vsync_q   <= 1'b0;
      href_q    <= 1'b0;
      data_q    <= '0;
      vsync_p_q <= 1'b0;
      href_p_q  <= 1'b0;
    end else begin
      vsync_q   <= vsync_d;
      href_q    <= href_d;
      data_q    <= data_d;
      vsync_p_q <= vsync_p_d;
      href_p_q  <= href_p_d;
    end
  end

  assign vsync_r    = vsync_q;
  assign href_r     = href_q;
  assign data_r     = data_q;
  assign vsync_rise = vsync_q & ~vsync_p_q;
  assign vsync_fall = ~vsync_q & vsync_p_q;
  assign href_fall  = ~href_q & href_p_q;

endmodule

// File: rtl/camera_capture.sv
// OV7670 frame capture: byte pairing, geometry check, frame_done/frame_err.
// CAMERA_CAPTURE_CONTINUOUS_EN: re-arm every frame with a pulsed frame_done.
module camera_capture
  import cam_pkg::*;
#(
  parameter int FRAME_W = FRAME_W_DEF,
  parameter int FRAME_H = FRAME_H_DEF
) (
  input logic             clk,
  input logic             reset,
  camera_capture_if.slave bus
);

  localparam logic [X_W-1:0] W_LIM = X_W'(FRAME_W);
  localparam logic [Y_W-1:0] H_LIM = Y_W'(FRAME_H);
  localparam logic [X_W-1:0] X_MAX = '1;
  localparam logic [Y_W-1:0] Y_MAX = '1;

  logic              vsync_r, href_r;
  logic [BYTE_W-1:0] data_r;
  logic              vsync_rise, vsync_fall, href_fall;

  cam_bus_sync u_sync (
    .clk        (clk),
    .reset      (reset),
    .vsync_i    (bus.cam_vsync),
    .href_i     (bus.cam_href),
    .data_i     (bus.cam_data),
    .vsync_r    (vsync_r),
    .href_r     (href_r),
    .data_r     (data_r),
    .vsync_rise (vsync_rise),
    .vsync_fall (vsync_fall),
    .href_fall  (href_fall)
  );

  cap_state_e        state_q, state_d;
  logic              phase_q, phase_d;
  logic [BYTE_W-1:0] byte0_q, byte0_d;
  logic [X_W-1:0]    col_q, col_d;
  logic [Y_W-1:0]    row_q, row_d;
  logic              has_q, has_d;
  logic              err_acc_q, err_acc_d;
  logic [31:0]       data_out_q, data_out_d;
  logic              pixel_done_q, pixel_done_d;
  logic              frame_done_q, frame_done_d;
  logic              frame_err_q, frame_err_d;
  logic [X_W-1:0]    pix_x_q, pix_x_d;
  logic [Y_W-1:0]    pix_y_q, pix_y_d;

  always_comb begin
    state_d      = state_q;
    phase_d      = phase_q;
    byte0_d      = byte0_q;
    col_d        = col_q;
    row_d        = row_q;
    has_d        = has_q;
    err_acc_d    = err_acc_q;
    data_out_d   = data_out_q;
    pixel_done_d = 1'b0;
    frame_err_d  = frame_err_q;
    pix_x_d      = pix_x_q;
    pix_y_d      = pix_y_q;
`ifdef CAMERA_CAPTURE_CONTINUOUS_EN
    frame_done_d = 1'b0;
`else
    frame_done_d = frame_done_q;
`endif
    unique case (state_q)
      WAIT_BLANK: begin
        if (vsync_r) state_d = WAIT_START;
      end
      WAIT_START: begin
        if (vsync_fall) begin
          state_d   = ACTIVE;
          phase_d   = 1'b0;
          col_d     = '0;
          row_d     = '0;
          has_d     = 1'b0;
          err_acc_d = 1'b0;
        end
      end
      ACTIVE: begin
        if (href_r) begin
          has_d = 1'b1;
          if (!phase_q) begin
            byte0_d = data_r;
            phase_d = 1'b1;
          end else begin
            phase_d = 1'b0;
            if (col_q < W_LIM && row_q < H_LIM) begin
              data_out_d   = pack_pixel(byte0_q, data_r);
              pixel_done_d = 1'b1;
              pix_x_d      = col_q;
              pix_y_d      = row_q;
            end else begin
              err_acc_d = 1'b1;
            end
            if (col_q != X_MAX) col_d = col_q + 1'b1;
          end
        end
        // a vsync rise during a byte also closes the open line
        if ((href_fall || (vsync_rise && href_r)) && has_d) begin
          if (phase_d || col_d != W_LIM) err_acc_d = 1'b1;
          if (row_d != Y_MAX) row_d = row_d + 1'b1;
          phase_d = 1'b0;
          col_d   = '0;
          has_d   = 1'b0;
        end
        if (vsync_rise) begin
          frame_err_d = err_acc_d | (row_d != H_LIM);
          err_acc_d   = 1'b0;
          state_d     = DONE;
        end
      end
      DONE: begin
        frame_done_d = 1'b1;
`ifdef CAMERA_CAPTURE_CONTINUOUS_EN
        state_d = WAIT_START;
`endif
      end
      default: state_d = WAIT_BLANK;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= WAIT_BLANK;
      phase_q      <= 1'b0;
      byte0_q      <= '0;
      col_q        <= '0;
      row_q        <= '0;
      has_q        <= 1'b0;
      err_acc_q    <= 1'b0;
      data_out_q   <= '0;
      pixel_done_q <= 1'b0;
      frame_done_q <= 1'b0;
      frame_err_q  <= 1'b0;
      pix_x_q      <= '0;
      pix_y_q      <= '0;
    end else begin
      state_q      <= state_d;
      phase_q      <= phase_d;
      byte0_q      <= byte0_d;
      col_q        <= col_d;
      row_q        <= row_d;
      has_q        <= has_d;
      err_acc_q    <= err_acc_d;
      data_out_q   <= data_out_d;
      pixel_done_q <= pixel_done_d;
      frame_done_q <= frame_done_d;
      frame_err_q  <= frame_err_d;
      pix_x_q      <= pix_x_d;
      pix_y_q      <= pix_y_d;
    end
  end

  assign bus.data_out   = data_out_q;
  assign bus.pixel_done = pixel_done_q;
  assign bus.frame_done = frame_done_q;
  assign bus.frame_err  = frame_err_q;
  assign bus.pix_x      = pix_x_q;
  assign bus.pix_y      = pix_y_q;

endmodule
